// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: top-level sequencer for the FPGA reaction game.
// Runs the mode-select, random-wait, stimulus and result phases, measures the
// reaction time in milliseconds and keeps the best score since reset. Every
// output comes straight from a register.

module reaction_game_ctrl #(
    parameter int unsigned CYCLES_PER_MS = 100000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_go,
    input  logic        btn_mode,
    output logic [13:0] number,
    output logic        select,
    output logic [1:0]  mode,
    output logic        led_go,
    output logic        early,
    output logic [13:0] best_ms,
    output logic        new_best
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_RESULT
    } state_t;

    localparam int unsigned   PW         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);
    localparam logic [13:0]   NUM_MAX    = 14'd9999;

    // Base wait before the stimulus, in ms, for the selected difficulty.
    function automatic logic [11:0] delay_base(input logic [1:0] m);
        case (m)
            2'b01:   return 12'd1000;
            2'b10:   return 12'd500;
            default: return 12'd2000;
        endcase
    endfunction

    // Reaction counter value at which an unanswered stimulus becomes a miss.
    function automatic logic [13:0] go_limit(input logic [1:0] m);
        case (m)
            2'b01:   return 14'd1000;
            2'b10:   return 14'd500;
            default: return 14'd9999;
        endcase
    endfunction

    state_t      state, state_d;
    logic [15:0] lfsr;
    logic [PW-1:0] presc, presc_d;
    logic [11:0] delay_cnt, delay_cnt_d;
    logic [13:0] ms_cnt, ms_cnt_d;
    logic [13:0] number_d, best_ms_d;
    logic [1:0]  mode_d;
    logic        select_d, led_go_d, early_d, new_best_d;
    logic        tick;

    assign tick = (presc == PRESC_LAST);

    // Free-running 16-bit Galois LFSR (taps 0xB400), advanced every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) so every register in the design samples
        // pre-edge values, independent of the order the blocks are evaluated.
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Next-state and next-output decode for the game sequencer.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the
        // case below can leave a value unassigned and infer a latch.
        state_d     = state;
        delay_cnt_d = delay_cnt;
        ms_cnt_d    = ms_cnt;
        number_d    = number;
        mode_d      = mode;
        early_d     = early;
        best_ms_d   = best_ms;
        new_best_d  = 1'b0;
        // The ms prescaler only runs while a round is timing something.
        if (state == S_WAIT || state == S_GO) begin
            presc_d = tick ? '0 : presc + PW'(1);
        end else begin
            presc_d = '0;
        end

        case (state)
            S_IDLE: begin
                if (btn_go) begin
                    delay_cnt_d = delay_base(mode) + {2'b00, lfsr[9:0]};
                    early_d     = 1'b0;
                    number_d    = '0;
                    presc_d     = '0;
                    state_d     = S_WAIT;
                end else if (btn_mode) begin
                    mode_d = (mode == 2'd2) ? 2'd0 : mode + 2'd1;
                end
            end
            S_WAIT: begin
                if (btn_go) begin
                    // False start: report the sentinel, leave best untouched.
                    early_d  = 1'b1;
                    number_d = NUM_MAX;
                    state_d  = S_RESULT;
                end else if (tick) begin
                    if (delay_cnt <= 12'd1) begin
                        delay_cnt_d = '0;
                        ms_cnt_d    = '0;
                        number_d    = '0;
                        presc_d     = '0;
                        state_d     = S_GO;
                    end else begin
                        delay_cnt_d = delay_cnt - 12'd1;
                    end
                end
            end
            S_GO: begin
                // A press coinciding with a tick wins; that tick is dropped.
                if (btn_go) begin
                    number_d = ms_cnt;
                    if (ms_cnt < best_ms) begin
                        best_ms_d  = ms_cnt;
                        new_best_d = 1'b1;
                    end
                    state_d = S_RESULT;
                end else if (tick) begin
                    if (ms_cnt + 14'd1 >= go_limit(mode)) begin
                        number_d = NUM_MAX;
                        state_d  = S_RESULT;
                    end else begin
                        ms_cnt_d = ms_cnt + 14'd1;
                        number_d = ms_cnt + 14'd1;
                    end
                end
            end
            S_RESULT: begin
                if (btn_go) begin
                    early_d  = 1'b0;
                    number_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        select_d = (state_d != S_IDLE);
        led_go_d = (state_d == S_GO);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            delay_cnt <= '0;
            ms_cnt    <= '0;
            number    <= '0;
            select    <= 1'b0;
            mode      <= 2'b00;
            led_go    <= 1'b0;
            early     <= 1'b0;
            best_ms   <= NUM_MAX;
            new_best  <= 1'b0;
        end else begin
            state     <= state_d;
            presc     <= presc_d;
            delay_cnt <= delay_cnt_d;
            ms_cnt    <= ms_cnt_d;
            number    <= number_d;
            select    <= select_d;
            mode      <= mode_d;
            led_go    <= led_go_d;
            early     <= early_d;
            best_ms   <= best_ms_d;
            new_best  <= new_best_d;
        end
    end

endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

Top-level sequencer for the FPGA reaction game. It runs the mode-select, random-wait, stimulus and result phases. It measures reaction time in milliseconds and tracks the best score. It drives the `number`, `select` and `mode` inputs of the four-digit seven-segment display driver, plus the stimulus LED.

## Interface
Parameters:
- `CYCLES_PER_MS`, 100000: `clk` cycles per 1 ms tick (100 MHz board clock).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `btn_go`, input, 1: debounced single-cycle press pulse, synchronous to `clk`.
- `btn_mode`, input, 1: debounced single-cycle press pulse, synchronous to `clk`.
- `number`, output, 14: value for the display (0–9999).
- `select`, output, 1: 0 = show mode word; 1 = show `number`.
- `mode`, output, 2: 00 easy, 01 regular, 10 hard; 11 is never driven.
- `led_go`, output, 1: stimulus LED, high only in GO.
- `early`, output, 1: high in RESULT when the round ended by a false start.
- `best_ms`, output, 14: best valid reaction since reset; 9999 if none yet.
- `new_best`, output, 1: one-cycle pulse when `best_ms` is updated.

## Operation
- States: IDLE, WAIT, GO, RESULT. All outputs are registered.
- Reset values:
  - state = IDLE, `mode` = 00, `number` = 0, `select` = 0, `led_go` = 0, `early` = 0.
  - `best_ms` = 9999, `new_best` = 0, LFSR = `LFSR_SEED`, all counters = 0.
- LFSR: 16-bit Galois, taps 0xB400. Advances every `clk` cycle in every state.
- ms tick: a prescaler counts 0..`CYCLES_PER_MS`−1 and asserts a tick on the terminal count. The prescaler clears to 0 on every entry to WAIT and GO, so the first ms is a full ms.
- IDLE (`select` = 0):
  - `btn_mode` cycles `mode` 00→01→10→00.
  - `btn_go` samples the LFSR, loads the delay count, clears `early`, then goes to WAIT.
  - When both buttons pulse in the same cycle, `btn_go` wins and `mode` is unchanged.
- Delay count = base + `lfsr[9:0]` ms. Base is 2000 for easy, 1000 for regular, 500 for hard.
- WAIT (`select` = 1, `number` = 0, `led_go` = 0):
  - The delay count decrements on each tick. When it reaches 0: clear the ms counter, go to GO.
  - `btn_go` in WAIT is a false start: `early` = 1, `number` = 9999, go to RESULT. `best_ms` is not updated.
- GO (`led_go` = 1, `select` = 1, `number` tracks the ms counter live):
  - The ms counter increments per tick.
  - Timeout limit: 9999 easy, 1000 regular, 500 hard.
  - `btn_go` latches the counter into `number` and goes to RESULT.
  - Counter reaching the limit without a press: `number` = 9999, go to RESULT. This is a miss; `best_ms` is not updated.
  - A press in the same cycle as a tick: the press wins, and that tick is not counted.
- Valid result: if `number` < `best_ms`, `best_ms` ← `number` and `new_best` pulses, both in the GO→RESULT transition cycle.
- RESULT (`select` = 1, `number` held, `led_go` = 0):
  - `btn_go` returns to IDLE. `mode` is retained; `early` clears on IDLE entry.
  - `btn_mode` is ignored in WAIT, GO and RESULT.
- Reset mid-round returns immediately to the reset values, including `best_ms`.

## Timing
- Button pulse at edge N: the state change and output update are visible after edge N+1 (one-cycle latency).
- WAIT length = delay × `CYCLES_PER_MS` cycles, ±1 cycle.
- Reported reaction equals the number of full ms elapsed between `led_go` rising and the press. Truncated; 0 is legal.
- `number` always stays in 0..9999. Counters saturate and never wrap.

## Test plan
For simulation, `CYCLES_PER_MS` = 4 and the LFSR is forced where noted.
- Mode cycling: reset, then 4× `btn_mode` → `mode` goes 01, 10, 00, 01; `select` stays 0.
- Regular round: LFSR[9:0] = 0 → WAIT lasts 1000 ticks (4000 cycles), `led_go` rises. `btn_go` 37 ticks later → `number` = 37, `best_ms` = 37, `new_best` pulses exactly once.
- False start: `btn_go` 10 ticks into WAIT → RESULT with `early` = 1, `number` = 9999, `led_go` never asserted, `best_ms` unchanged.
- Hard timeout: no press in GO → after 500 ticks, `number` = 9999, state RESULT, `best_ms` unchanged.
- Best tracking: rounds of 120, 80 and 95 ms → `best_ms` goes 120, 80, 80; `new_best` pulses only on the first two.
- Async reset: drive `rst_n` low mid-GO, asynchronous to `clk` → all outputs at reset values before the next edge; mode select resumes after release.
